// File: rtl/contador_ajuste_bcd_param_pkg.sv
// Shared definitions for the adjustable time-field counters: key auto-repeat
// state encoding, standard field limits/select codes and a 0..99 to BCD helper.
package contador_ajuste_bcd_param_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } rpt_state_t;

    localparam int SEC_MAX  = 59;
    localparam int MIN_MAX  = 59;
    localparam int HOUR_MAX = 23;

    localparam logic [3:0] FIELD_SEC  = 4'd1;
    localparam logic [3:0] FIELD_MIN  = 4'd2;
    localparam logic [3:0] FIELD_HOUR = 4'd3;

    // Splits a binary value in 0..99 into {tens, units} BCD digits.
    function automatic logic [7:0] bin_to_bcd(input logic [6:0] value);
        return {4'(value / 7'd10), 4'(value % 7'd10)};
    endfunction

endpackage

// File: rtl/contador_ajuste_bcd_param_rpt_tecla.sv
// Key auto-repeat: one step on press, a second after HOLD_DELAY cycles held,
// then one every REPEAT_PERIOD cycles. Dropping the key or changing direction
// returns to IDLE without stepping; abort forces IDLE immediately.
module rpt_tecla
    import contador_ajuste_bcd_param_pkg::*;
#(
    parameter int HOLD_DELAY    = 50_000_000,
    parameter int REPEAT_PERIOD = 13_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic key,
    input  logic dir_in,
    input  logic abort,
    output logic step,
    output logic dir
);

    localparam int MAX_WAIT = (HOLD_DELAY > REPEAT_PERIOD) ? HOLD_DELAY : REPEAT_PERIOD;
    localparam int TW       = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [TW-1:0] HOLD_LAST   = TW'(HOLD_DELAY - 1);
    localparam logic [TW-1:0] REPEAT_LAST = TW'(REPEAT_PERIOD - 1);

    rpt_state_t    state;
    rpt_state_t    state_next;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_next;
    logic          dir_q;
    logic          dir_next;
    logic          changed;

    assign changed = (dir_in != dir_q);

    // State, timer and latched direction registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            timer <= '0;
            dir_q <= 1'b0;
        end else begin
            state <= state_next;
            timer <= timer_next;
            dir_q <= dir_next;
        end
    end

    // Next state: the timer runs in HOLD/REPEAT and is cleared on every step or exit.
    always_comb begin
        state_next = state;
        timer_next = timer;
        dir_next   = dir_q;
        if (abort) begin
            state_next = IDLE;
            timer_next = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (key) begin
                        state_next = HOLD;
                        timer_next = '0;
                        dir_next   = dir_in;
                    end
                end
                HOLD: begin
                    if (!key || changed) begin
                        state_next = IDLE;
                        timer_next = '0;
                    end else if (timer == HOLD_LAST) begin
                        state_next = REPEAT;
                        timer_next = '0;
                    end else begin
                        timer_next = timer + TW'(1);
                    end
                end
                REPEAT: begin
                    if (!key || changed) begin
                        state_next = IDLE;
                        timer_next = '0;
                    end else if (timer == REPEAT_LAST) begin
                        timer_next = '0;
                    end else begin
                        timer_next = timer + TW'(1);
                    end
                end
                default: begin
                    state_next = IDLE;
                    timer_next = '0;
                end
            endcase
        end
    end

    // Step strobe: immediate on press, then on each timer expiry while the key holds.
    always_comb begin
        step = 1'b0;
        dir  = dir_q;
        if (!abort) begin
            case (state)
                IDLE: begin
                    if (key) begin
                        step = 1'b1;
                        dir  = dir_in;
                    end
                end
                HOLD:    step = key && !changed && (timer == HOLD_LAST);
                REPEAT:  step = key && !changed && (timer == REPEAT_LAST);
                default: step = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/contador_ajuste_bcd_param.sv
// One adjustable time field (hours, minutes or seconds): key-driven up/down
// adjust with auto-repeat, cascade increment with carry, synchronous load, and
// registered BCD decode with optional 12 h display for the hour field.
module contador_ajuste_bcd_param
    import contador_ajuste_bcd_param_pkg::*;
#(
    parameter int MOD_MAX       = HOUR_MAX,
    parameter int N             = 7,
    parameter int FIELD_ID      = 3,
    parameter int HOUR_MODE     = 1,
    parameter int HOLD_DELAY    = 50_000_000,
    parameter int REPEAT_PERIOD = 13_000_000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enUP,
    input  logic         enDOWN,
    input  logic [3:0]   en_count,
    input  logic         formato_hora,
    input  logic         inc_tick,
    input  logic         load,
    input  logic [N-1:0] load_value,
    output logic [N-1:0] count,
    output logic         carry_out,
    output logic [3:0]   digit1,
    output logic [3:0]   digit0,
    output logic         AM_PM
);

    localparam logic [N-1:0] MAX_VAL = N'(MOD_MAX);

    logic       sel;
    logic       key;
    logic       step;
    logic       dir;
    logic [6:0] value;
    logic [6:0] hour12;
    logic [7:0] bcd;
    logic       pm;

    assign sel = (en_count == 4'(FIELD_ID));
    assign key = sel & (enUP ^ enDOWN);

    rpt_tecla #(
        .HOLD_DELAY    (HOLD_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_rpt (
        .clk    (clk),
        .reset  (reset),
        .key    (key),
        .dir_in (enUP),
        .abort  (load),
        .step   (step),
        .dir    (dir)
    );

    // Counter with priority load > adjust step > cascade tick; only tick wraps carry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count     <= '0;
            carry_out <= 1'b0;
        end else begin
            carry_out <= 1'b0;
            if (load) begin
                if (load_value <= MAX_VAL) begin
                    count <= load_value;
                end
            end else if (step) begin
                if (dir) begin
                    count <= (count == MAX_VAL) ? '0 : count + N'(1);
                end else begin
                    count <= (count == '0) ? MAX_VAL : count - N'(1);
                end
            end else if (inc_tick && !sel) begin
                count     <= (count == MAX_VAL) ? '0 : count + N'(1);
                carry_out <= (count == MAX_VAL);
            end
        end
    end

    // Display value: plain decimal, or 1..12 with AM/PM when 12 h format is active.
    always_comb begin
        value  = 7'(count);
        hour12 = '0;
        pm     = 1'b0;
        bcd    = bin_to_bcd(value);
        if ((HOUR_MODE != 0) && formato_hora) begin
            hour12 = value % 7'd12;
            if (hour12 == 7'd0) begin
                hour12 = 7'd12;
            end
            pm  = (value >= 7'd12);
            bcd = bin_to_bcd(hour12);
        end
    end

    // Registered decode outputs, one cycle behind count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digit1 <= 4'd0;
            digit0 <= 4'd0;
            AM_PM  <= 1'b0;
        end else begin
            digit1 <= bcd[7:4];
            digit0 <= bcd[3:0];
            AM_PM  <= pm;
        end
    end

endmodule

// File: tb/tb_contador_ajuste_bcd_param.sv
// Bench for contador_ajuste_bcd_param: directed scenarios followed by random
// key presses, cascade ticks and loads checked against an arithmetic model.
module tb_contador_ajuste_bcd_param;

    localparam int MOD_MAX = 23;
    localparam int HD      = 4;
    localparam int RP      = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       enUP;
    logic       enDOWN;
    logic [3:0] en_count;
    logic       formato_hora;
    logic       inc_tick;
    logic       load;
    logic [6:0] load_value;
    logic [6:0] count;
    logic       carry_out;
    logic [3:0] digit1;
    logic [3:0] digit0;
    logic       AM_PM;

    int checks = 0;
    int passes = 0;
    int mc;

    contador_ajuste_bcd_param #(
        .MOD_MAX       (MOD_MAX),
        .N             (7),
        .FIELD_ID      (3),
        .HOUR_MODE     (1),
        .HOLD_DELAY    (HD),
        .REPEAT_PERIOD (RP)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enUP         (enUP),
        .enDOWN       (enDOWN),
        .en_count     (en_count),
        .formato_hora (formato_hora),
        .inc_tick     (inc_tick),
        .load         (load),
        .load_value   (load_value),
        .count        (count),
        .carry_out    (carry_out),
        .digit1       (digit1),
        .digit0       (digit0),
        .AM_PM        (AM_PM)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [3:0] en, input logic up, input logic down,
                                 input logic tick, input logic ld, input int ldv);
        en_count   = en;
        enUP       = up;
        enDOWN     = down;
        inc_tick   = tick;
        load       = ld;
        load_value = 7'(ldv);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks = checks + 1;
        assert (obs === expv) passes = passes + 1;
        else $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, expv);
    endtask

    task automatic modelDecode(input int c, input bit fmt, output int d1, output int d0, output int pm);
        int h;
        if (fmt) begin
            h = c % 12;
            if (h == 0) h = 12;
            d1 = h / 10;
            d0 = h % 10;
            pm = (c >= 12) ? 1 : 0;
        end else begin
            d1 = c / 10;
            d0 = c % 10;
            pm = 0;
        end
    endtask

    task automatic checkDecode(input string tag, input int c, input bit fmt);
        int d1, d0, pm;
        modelDecode(c, fmt, d1, d0, pm);
        checkOutput({tag, "_digit1"}, 32'(digit1), d1);
        checkOutput({tag, "_digit0"}, 32'(digit0), d0);
        if (fmt) checkOutput({tag, "_ampm"}, 32'(AM_PM), pm);
    endtask

    function automatic int stepUp(input int c);
        return (c == MOD_MAX) ? 0 : c + 1;
    endfunction

    function automatic int stepDown(input int c);
        return (c == 0) ? MOD_MAX : c - 1;
    endfunction

    initial begin
        int op, len, nsteps, v, e;
        bit up, fmt, exp_carry;

        reset        = 1'b1;
        formato_hora = 1'b1;
        applyStimulus(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        cyc(2);
        checkOutput("rst_count", 32'(count), 0);
        checkOutput("rst_carry", 32'(carry_out), 0);
        checkOutput("rst_digit1", 32'(digit1), 0);
        checkOutput("rst_digit0", 32'(digit0), 0);
        checkOutput("rst_ampm", 32'(AM_PM), 0);
        reset = 1'b0;
        cyc(1);
        checkOutput("rel_count", 32'(count), 0);
        checkDecode("rel", 0, 1'b1);

        $display("[TB] held enUP auto-repeat");
        applyStimulus(4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        cyc(1);
        checkOutput("hold_first_step", 32'(count), 1);
        cyc(4);
        checkOutput("hold_delay_step", 32'(count), 2);
        cyc(5);
        checkOutput("hold_ten_cycles", 32'(count), 4);
        applyStimulus(4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        cyc(5);
        checkOutput("hold_released", 32'(count), 4);

        $display("[TB] enDOWN pulse wraps 0 to max");
        applyStimulus(4'd3, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        cyc(1);
        applyStimulus(4'd3, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        cyc(1);
        applyStimulus(4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        checkOutput("down_wrap", 32'(count), 23);
        cyc(1);
        checkDecode("down_12h", 23, 1'b1);
        formato_hora = 1'b0;
        cyc(1);
        checkDecode("down_24h", 23, 1'b0);
        checkOutput("down_24h_count", 32'(count), 23);

        $display("[TB] cascade tick and carry");
        applyStimulus(4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        cyc(1);
        applyStimulus(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        checkOutput("tick_wrap", 32'(count), 0);
        checkOutput("tick_carry", 32'(carry_out), 1);
        cyc(1);
        checkOutput("tick_carry_drop", 32'(carry_out), 0);
        applyStimulus(4'd3, 1'b0, 1'b0, 1'b0, 1'b1, 23);
        cyc(1);
        applyStimulus(4'd3, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        cyc(1);
        applyStimulus(4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        checkOutput("tick_sel_count", 32'(count), 23);
        checkOutput("tick_sel_carry", 32'(carry_out), 0);
        cyc(1);
        checkOutput("tick_sel_carry2", 32'(carry_out), 0);

        $display("[TB] both keys and load bounds");
        applyStimulus(4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        cyc(6);
        checkOutput("both_keys", 32'(count), 23);
        applyStimulus(4'd3, 1'b0, 1'b0, 1'b0, 1'b1, 30);
        cyc(1);
        checkOutput("load_oob", 32'(count), 23);
        applyStimulus(4'd3, 1'b0, 1'b0, 1'b0, 1'b1, 13);
        cyc(1);
        applyStimulus(4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        checkOutput("load_13", 32'(count), 13);
        formato_hora = 1'b1;
        cyc(1);
        checkDecode("load_13_12h", 13, 1'b1);

        $display("[TB] reset during repeat");
        applyStimulus(4'd3, 1'b0, 1'b0, 1'b0, 1'b1, 4);
        cyc(1);
        applyStimulus(4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        cyc(7);
        checkOutput("pre_reset_count", 32'(count), 7);
        #2 reset = 1'b1;
        #1;
        checkOutput("async_count", 32'(count), 0);
        checkOutput("async_carry", 32'(carry_out), 0);
        checkOutput("async_digit1", 32'(digit1), 0);
        checkOutput("async_digit0", 32'(digit0), 0);
        checkOutput("async_ampm", 32'(AM_PM), 0);
        applyStimulus(4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        cyc(2);
        reset = 1'b0;
        cyc(3);
        checkOutput("post_reset_count", 32'(count), 0);

        $display("[TB] random sequence");
        mc = 0;
        for (int it = 0; it < 40; it++) begin
            fmt = 1'($urandom_range(0, 1));
            formato_hora = fmt;
            op = $urandom_range(0, 2);
            if (op == 0) begin
                up  = 1'($urandom_range(0, 1));
                len = $urandom_range(1, 12);
                applyStimulus(4'd3, up, !up, 1'b0, 1'b0, 0);
                cyc(len);
                applyStimulus(4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 0);
                nsteps = 1;
                if (len - 1 >= HD) nsteps = 2 + (len - 1 - HD) / RP;
                for (int s = 0; s < nsteps; s++) mc = up ? stepUp(mc) : stepDown(mc);
                cyc(1);
                checkOutput("rnd_key_count", 32'(count), mc);
            end else if (op == 1) begin
                e = $urandom_range(0, 15);
                if (e == 3) begin
                    exp_carry = 1'b0;
                end else begin
                    exp_carry = (mc == MOD_MAX);
                    mc = stepUp(mc);
                end
                applyStimulus(4'(e), 1'b0, 1'b0, 1'b1, 1'b0, 0);
                cyc(1);
                applyStimulus(4'(e), 1'b0, 1'b0, 1'b0, 1'b0, 0);
                checkOutput("rnd_tick_count", 32'(count), mc);
                checkOutput("rnd_tick_carry", 32'(carry_out), 32'(exp_carry));
            end else begin
                v = $urandom_range(0, 40);
                if (v <= MOD_MAX) mc = v;
                applyStimulus(4'($urandom_range(0, 15)), 1'b0, 1'b0, 1'b0, 1'b1, v);
                cyc(1);
                applyStimulus(en_count, 1'b0, 1'b0, 1'b0, 1'b0, 0);
                checkOutput("rnd_load_count", 32'(count), mc);
            end
            cyc(1);
            checkOutput("rnd_carry_idle", 32'(carry_out), 0);
            checkDecode("rnd", mc, fmt);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
